// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline hazard logic.
//   hz_state_t : hazard FSM states (RUN, LDSTALL, BUSY)
//   FWD_*      : operand-source select codes driven on fwd_a / fwd_b
//   REG_ZERO   : hard-wired zero register, never a hazard or forward source
//   CNT_W      : width of the performance counters
//   fwd_sel    : forwarding select for one EX operand
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        BUSY    = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         CNT_W    = 16;

    // MEM is the younger producer, so it is checked before WB.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_dest,
        input logic       mem_wen,
        input logic [4:0] wb_dest,
        input logic       wb_wen
    );
        if (mem_wen && mem_dest != REG_ZERO && mem_dest == src)
            return FWD_MEM;
        else if (wb_wen && wb_dest != REG_ZERO && wb_dest == src)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter.
//   clk, rst : clock, synchronous active-high reset (clears count)
//   clr      : synchronous clear, wins over inc
//   inc      : add one this cycle unless already at all-ones
//   count    : current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc && count != {W{1'b1}})
            count <= count + W'(1);
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, multi-cycle ALU hold, jump-register
// flush, EX operand forwarding and stall/flush performance counters.
//   clk, rst                      : clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt      : source fields of the decode instruction
//   ex_rs, ex_rt, ex_dest, ...    : EX-stage operands, destination and kind
//   mem_*/wb_*                    : later-stage destinations and write enables
//   cnt_clr                       : clear both perf counters
//   pc_stall, if_id_stall         : hold PC and IF/ID
//   id_ex_bubble, if_id_flush     : zero ID/EX, zero IF/ID at next edge
//   ex_hold                       : freeze ID/EX and kill EX/MEM write enable
//   fwd_a, fwd_b                  : operand sources for ex_rs / ex_rt
//   stall_cnt, flush_cnt          : saturating perf counters
module hazard_unit
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_dest,
    input  logic             ex_reg_wen,
    input  logic             ex_dmem_alu,
    input  logic             ex_jr,
    input  logic             ex_busy,
    input  logic [4:0]       mem_dest,
    input  logic [4:0]       wb_dest,
    input  logic             mem_reg_wen,
    input  logic             wb_reg_wen,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             ex_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t state, state_next;
    logic      load_use;

    assign load_use = ex_reg_wen && ex_dmem_alu && ex_dest != REG_ZERO &&
                      (ex_dest == id_rs || (id_uses_rt && ex_dest == id_rt));

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = RUN;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        ex_hold      = 1'b0;
        if (!rst) begin
            case (state)
                BUSY: begin
                    // The cycle busy drops is the one the result leaves EX;
                    // no new hazard is raised in that cycle.
                    if (ex_busy) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        ex_hold     = 1'b1;
                        state_next  = BUSY;
                    end
                end
                default: begin
                    // RUN and LDSTALL evaluate identically; LDSTALL only marks
                    // that the previous cycle inserted a load-use bubble.
                    if (ex_busy) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        ex_hold     = 1'b1;
                        state_next  = BUSY;
                    end else if (ex_jr) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_next   = LDSTALL;
                    end
                end
            endcase
        end
    end

    assign fwd_a = fwd_sel(ex_rs, mem_dest, mem_reg_wen, wb_dest, wb_reg_wen);
    assign fwd_b = fwd_sel(ex_rt, mem_dest, mem_reg_wen, wb_dest, wb_reg_wen);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (pc_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (if_id_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
    logic        id_uses_rt, ex_reg_wen, ex_dmem_alu, ex_jr, ex_busy;
    logic        mem_reg_wen, wb_reg_wen, cnt_clr;
    logic        pc_stall, if_id_stall, id_ex_bubble, if_id_flush, ex_hold;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_reg_wen(ex_reg_wen), .ex_dmem_alu(ex_dmem_alu),
        .ex_jr(ex_jr), .ex_busy(ex_busy),
        .mem_dest(mem_dest), .wb_dest(wb_dest),
        .mem_reg_wen(mem_reg_wen), .wb_reg_wen(wb_reg_wen),
        .cnt_clr(cnt_clr),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .ex_hold(ex_hold), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
        logic id_uses_rt, ex_reg_wen, ex_dmem_alu, ex_jr, ex_busy;
        logic mem_reg_wen, wb_reg_wen, cnt_clr, rst;
    } stim_t;

    typedef struct {
        logic [4:0]  ctl;   // {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, ex_hold}
        logic [1:0]  fa, fb;
        logic [15:0] sc, fc;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0, n_total = 0;

    // Reference model: "the cycle right after an accepted busy stall"
    // swallows jr/load-use; everything else is a priority pick.
    bit      m_after_busy = 0;
    int      m_sc = 0, m_fc = 0;

    function automatic stim_t idle();
        stim_t s;
        s.id_rs = 0; s.id_rt = 0; s.ex_rs = 0; s.ex_rt = 0; s.ex_dest = 0;
        s.mem_dest = 0; s.wb_dest = 0; s.id_uses_rt = 0; s.ex_reg_wen = 0;
        s.ex_dmem_alu = 0; s.ex_jr = 0; s.ex_busy = 0; s.mem_reg_wen = 0;
        s.wb_reg_wen = 0; s.cnt_clr = 0; s.rst = 0;
        return s;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] src, input stim_t s);
        if (s.mem_reg_wen && s.mem_dest != 0 && s.mem_dest == src) return 2'b01;
        if (s.wb_reg_wen && s.wb_dest != 0 && s.wb_dest == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic apply(input stim_t s, input string tag, input bit chk = 1);
        exp_t e;
        bit   lu, st, sb, bub, fl, hd;
        @(negedge clk);
        rst = s.rst; id_rs = s.id_rs; id_rt = s.id_rt; id_uses_rt = s.id_uses_rt;
        ex_rs = s.ex_rs; ex_rt = s.ex_rt; ex_dest = s.ex_dest;
        ex_reg_wen = s.ex_reg_wen; ex_dmem_alu = s.ex_dmem_alu;
        ex_jr = s.ex_jr; ex_busy = s.ex_busy;
        mem_dest = s.mem_dest; wb_dest = s.wb_dest;
        mem_reg_wen = s.mem_reg_wen; wb_reg_wen = s.wb_reg_wen; cnt_clr = s.cnt_clr;

        lu = s.ex_reg_wen && s.ex_dmem_alu && s.ex_dest != 0 &&
             (s.ex_dest == s.id_rs || (s.id_uses_rt && s.ex_dest == s.id_rt));
        {st, sb, bub, fl, hd} = '0;
        if (!s.rst) begin
            if (s.ex_busy)          begin st = 1; sb = 1; hd = 1; end
            else if (m_after_busy)  ;
            else if (s.ex_jr)       begin fl = 1; bub = 1; end
            else if (lu)            begin st = 1; sb = 1; bub = 1; end
        end
        e.ctl = {st, sb, bub, fl, hd};
        e.fa  = ref_fwd(s.ex_rs, s);
        e.fb  = ref_fwd(s.ex_rt, s);
        e.sc  = 16'(m_sc);
        e.fc  = 16'(m_fc);
        e.tag = tag;
        if (chk) q.push_back(e);

        if (s.rst || s.cnt_clr) begin m_sc = 0; m_fc = 0; end
        else begin
            if (st && m_sc < 65535) m_sc++;
            if (fl && m_fc < 65535) m_fc++;
        end
        m_after_busy = !s.rst && s.ex_busy;
    endtask

    task automatic check(input string name, input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s [%s]: got %h, expected %h", name, tag, got, exp);
    endtask

    // Monitor: outputs are valid once the driver has settled the inputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                check("ctl", e.tag, {11'd0, pc_stall, if_id_stall, id_ex_bubble,
                                     if_id_flush, ex_hold}, {11'd0, e.ctl});
                check("fwd", e.tag, {12'd0, fwd_a, fwd_b}, {12'd0, e.fa, e.fb});
                check("stall_cnt", e.tag, stall_cnt, e.sc);
                check("flush_cnt", e.tag, flush_cnt, e.fc);
            end
        end
    end

    initial begin
        stim_t s;
        s = idle(); s.rst = 1;
        apply(s, "rst0", 0);
        apply(s, "rst1");
        s.ex_busy = 1;                       // reset masks all stalls
        apply(s, "rst_busy");

        // load to r5, decode reads rs=5: one stall, then clear
        s = idle(); s.ex_reg_wen = 1; s.ex_dmem_alu = 1; s.ex_dest = 5; s.id_rs = 5;
        apply(s, "lu_r5");
        s = idle();
        apply(s, "lu_after");
        apply(s, "lu_cnt");
        // load-use through rt only when rt is read
        s = idle(); s.ex_reg_wen = 1; s.ex_dmem_alu = 1; s.ex_dest = 9; s.id_rt = 9;
        apply(s, "lu_rt_unused");
        s.id_uses_rt = 1;
        apply(s, "lu_rt_used");
        // load to r0: no stall, no forward
        s = idle(); s.ex_reg_wen = 1; s.ex_dmem_alu = 1; s.ex_dest = 0;
        s.mem_reg_wen = 1; s.wb_reg_wen = 1;
        apply(s, "lu_r0");
        // jr beats load-use
        s = idle(); s.ex_reg_wen = 1; s.ex_dmem_alu = 1; s.ex_dest = 3; s.id_rs = 3;
        s.ex_jr = 1;
        apply(s, "jr_lu");
        apply(idle(), "jr_after");
        // busy 3 cycles, then released
        s = idle(); s.ex_busy = 1;
        repeat (3) apply(s, "busy3");
        s = idle(); s.ex_jr = 1;             // swallowed on release cycle
        apply(s, "busy_rel");
        apply(idle(), "busy_idle");
        // busy interrupted by reset in cycle 2
        s = idle(); s.ex_busy = 1;
        apply(s, "busy_r1");
        s.rst = 1;
        apply(s, "busy_rst");
        s = idle(); s.ex_reg_wen = 1; s.ex_dmem_alu = 1; s.ex_dest = 4; s.id_rs = 4;
        apply(s, "post_rst_lu");
        // forwarding priority
        s = idle(); s.ex_rs = 7; s.ex_rt = 7; s.mem_dest = 7; s.wb_dest = 7;
        s.mem_reg_wen = 1; s.wb_reg_wen = 1;
        apply(s, "fwd_mem");
        s.mem_reg_wen = 0;
        apply(s, "fwd_wb");
        s.wb_reg_wen = 0;
        apply(s, "fwd_rf");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.id_rs = 5'($urandom_range(0, 3)); s.id_rt = 5'($urandom_range(0, 3));
            s.ex_rs = 5'($urandom_range(0, 3)); s.ex_rt = 5'($urandom_range(0, 3));
            s.ex_dest = 5'($urandom_range(0, 3));
            s.mem_dest = 5'($urandom_range(0, 3)); s.wb_dest = 5'($urandom_range(0, 3));
            s.id_uses_rt = 1'($urandom); s.ex_reg_wen = 1'($urandom);
            s.ex_dmem_alu = 1'($urandom); s.mem_reg_wen = 1'($urandom);
            s.wb_reg_wen = 1'($urandom);
            s.ex_jr = ($urandom_range(0, 5) == 0);
            s.ex_busy = ($urandom_range(0, 7) == 0);
            s.cnt_clr = ($urandom_range(0, 49) == 0);
            s.rst = ($urandom_range(0, 199) == 0);
            apply(s, "rand");
        end

        // saturation: drive stall_cnt to FFFE, then past it, then clear
        s = idle(); s.cnt_clr = 1;
        apply(s, "sat_clr");
        s = idle(); s.ex_busy = 1;
        repeat (65534) apply(s, "sat_ramp");
        apply(s, "sat_fffe");
        apply(s, "sat_ffff");
        s.cnt_clr = 1;
        apply(s, "sat_hold_clr");
        apply(idle(), "sat_zero");
        apply(idle(), "end");

        @(negedge clk);
        #4;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have ports, one per line, clock and reset first: name  direction  width  meaning.
  clk  in  1  clock, rising-edge; rst  in  1  reset, synchronous, active-high
  id_rs  in  5  rs field of the instruction in decode
  id_rt  in  5  rt field of the instruction in decode
  id_uses_rt  in  1  decode instruction reads rt
  ex_rs  in  5  rs captured by the ID/EX register
  ex_rt  in  5  rt captured by the ID/EX register
  ex_dest  in  5  EX destination register (rd or rt after reg_des select)
  ex_reg_wen  in  1  EX instruction writes the register file
  ex_dmem_alu  in  1  EX instruction is a load
  ex_jr  in  1  EX instruction is a jump-register
  ex_busy  in  1  multi-cycle ALU op in EX not yet done
  mem_dest, wb_dest  in  5  destinations in MEM and WB
  mem_reg_wen, wb_reg_wen  in  1  write enables in MEM and WB
  cnt_clr  in  1  clear perf counters
  pc_stall, if_id_stall  out  1  hold PC and IF/ID
  id_ex_bubble  out  1  load zeros into ID/EX next edge
  if_id_flush  out  1  zero IF/ID next edge
  ex_hold  out  1  hold ID/EX and suppress EX/MEM write-enable
  fwd_a, fwd_b  out  2  operand source for ex_rs/ex_rt: 00 regfile, 01 MEM, 10 WB
  stall_cnt, flush_cnt  out  16  saturating perf counters

Function
REQ-002 SHALL implement FSM states RUN, LDSTALL, BUSY; state register only sequential control.
REQ-003 SHALL define load-use hazard LU = ex_reg_wen & ex_dmem_alu & ex_dest!=0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)).
REQ-004 In RUN with ex_busy=1: pc_stall=if_id_stall=ex_hold=1, id_ex_bubble=0; next BUSY.
REQ-005 In BUSY: same outputs as REQ-004 while ex_busy=1; on ex_busy=0 all stall outputs 0 that cycle, next RUN.
REQ-006 In RUN with ex_busy=0 and ex_jr=1: if_id_flush=1, id_ex_bubble=1, no stalls; next RUN; jr wins over LU.
REQ-007 In RUN with ex_busy=0, ex_jr=0, LU=1: pc_stall=if_id_stall=id_ex_bubble=1; next LDSTALL.
REQ-008 In LDSTALL: all stall/flush outputs 0 unless a new condition per REQ-004/006/007 applies (evaluated as in RUN); next per those rules, else RUN.
REQ-009 Priority for simultaneous events: ex_busy > ex_jr > LU.
REQ-010 fwd_a SHALL be combinational: 01 if mem_reg_wen & mem_dest!=0 & mem_dest==ex_rs; else 10 if wb_reg_wen & wb_dest!=0 & wb_dest==ex_rs; else 00; fwd_b identically with ex_rt.
REQ-011 Register 0 SHALL never forward or trigger LU.
REQ-012 stall_cnt SHALL increment by 1 each cycle pc_stall=1; flush_cnt each cycle if_id_flush=1; both saturate at 16'hFFFF.
REQ-013 cnt_clr=1 SHALL zero both counters at the next edge, overriding increment.

Reset
REQ-014 rst=1 at rising edge SHALL force state RUN, stall_cnt=0, flush_cnt=0.
REQ-015 While rst=1 all stall/flush outputs SHALL be 0; fwd_a/fwd_b remain combinational.
REQ-016 rst mid-LDSTALL or mid-BUSY SHALL abort to RUN with no residual stall the following cycle.

Structure
REQ-017 Shared package cpu_pkg SHALL hold state enum, fwd select constants (FWD_RF, FWD_MEM, FWD_WB), REG_ZERO, CNT_W=16.
REQ-018 One sub-module sat_counter (width param, inc, clr, rst) SHALL be instantiated twice.

Verification
REQ-019 Load to r5 in EX, decode reads rs=5 -> pc_stall/if_id_stall/id_ex_bubble=1 one cycle, then 0; stall_cnt=1.
REQ-020 Load to r0 in EX, decode rs=0 -> no stall; fwd_a=00.
REQ-021 ex_jr=1 with LU=1 same cycle -> if_id_flush=1, id_ex_bubble=1, pc_stall=0; flush_cnt=1.
REQ-022 ex_busy high 3 cycles -> pc_stall/ex_hold=1 exactly 3 cycles; stall_cnt=3; rst in cycle 2 -> outputs 0 next cycle, counters 0.
REQ-023 mem_dest=wb_dest=ex_rs=7, both wen=1 -> fwd_a=01; drop mem_reg_wen -> fwd_a=10.
REQ-024 Force stall_cnt to 16'hFFFE, two stall cycles -> holds 16'hFFFF; cnt_clr=1 with stall -> 0.
